uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/InstructionStruct.sv | 17 +
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/InstructionStruct.sv
// Shared UART types: FSM state encoding and character width.
// PARITY exists only when UART_TX_PARITY_EN is defined.
package InstructionStruct;

  localparam int UART_CHAR_WIDTH = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular character buffer for uart_tx. DEPTH must be a power of two so the
// pointers wrap naturally; ready depends only on the registered count.
module uart_fifo
  import InstructionStruct::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [UART_CHAR_WIDTH-1:0] wr_data_i,
  output logic [UART_CHAR_WIDTH-1:0] rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ready_o
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_CHAR_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]              wr_ptr_q;
  logic [AW-1:0]              rd_ptr_q;
  logic [AW:0]                count_q;
  logic                       push_ok;

  assign ready_o   = (count_q < (AW+1)'(DEPTH));
  assign push_ok   = push_i && ready_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered 7-bit UART transmitter: start, 7 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_tx
  import InstructionStruct::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [UART_CHAR_WIDTH-1:0]  char_data,
  input  logic                        char_valid,
  output logic                        char_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_CHAR_WIDTH - 1);

  uart_state_t                state_q;
  logic [BW-1:0]              baud_q;
  logic [2:0]                 bit_idx_q;
  logic [UART_CHAR_WIDTH-1:0] shift_q;
  logic                       txd_q;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q;
`endif

  logic [UART_CHAR_WIDTH-1:0] fifo_head;
  logic                       fifo_nonempty;
  logic                       baud_done;
  logic                       pop;

  assign fifo_nonempty = (fifo_count != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  // Pop from IDLE, or at the very end of STOP so frames run back to back.
  assign pop = fifo_nonempty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));

  assign txd  = txd_q;
  assign busy = (state_q != IDLE) || fifo_nonempty;

  uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (char_valid),
    .pop_i    (pop),
    .wr_data_i(char_data),
    .rd_data_o(fifo_head),
    .count_o  (fifo_count),
    .ready_o  (char_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift_q  <= fifo_head;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^fifo_head;
`endif
      end
      case (state_q)
        IDLE: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          txd_q     <= 1'b1;
          if (pop) begin
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            txd_q     <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              txd_q     <= parity_q;
`else
              state_q   <= STOP;
              txd_q     <= 1'b1;
`endif
            end else begin
              // Next data bit is the one about to shift into position 0.
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= STOP;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          baud_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8); frame length
// follows UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic       clk;
  logic       reset;
  logic [6:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       txd;
  logic       busy;
  logic [3:0] fifo_count;

  int checks;
  int failures;

  typedef struct {
    logic [6:0] ch;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .char_data (char_data),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] ch);
    @(negedge clk);
    char_data  = ch;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  // Samples every cycle of one frame; the first sample is the edge after the call.
  task automatic check_frame(input logic [6:0] ch, input logic par);
    logic [9:0] exp_bits;
    logic       got;
    exp_bits = {1'b1, par, ch, 1'b0};
    if (NBITS == 9) exp_bits[8] = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      got = exp_bits[b];
      for (int c = 0; c < CPB; c++) begin
        sample();
        if (txd !== exp_bits[b]) got = txd;
      end
      chk($sformatf("frame_%02h_bit%0d", ch, b), {31'd0, got}, {31'd0, exp_bits[b]});
    end
    $display("frame ch=%02h par=%0b checked", ch, par);
  endtask

  initial begin
    logic ok;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    char_valid = 1'b0;
    char_data  = 7'h00;

    vecs[0] = '{ch: 7'h41, par: 1'b0};
    vecs[1] = '{ch: 7'h00, par: 1'b0};
    vecs[2] = '{ch: 7'h7F, par: 1'b1};
    vecs[3] = '{ch: 7'h55, par: 1'b0};
    vecs[4] = '{ch: 7'h2A, par: 1'b1};
    vecs[5] = '{ch: 7'h43, par: 1'b1};

    #12;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, char_ready}, 32'd1);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sample();
    repeat (3) sample();
    chk("idle_txd", {31'd0, txd}, 32'd1);

    // Single frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].ch);
      chk($sformatf("v%0d_count_after_push", i), {28'd0, fifo_count}, 32'd1);
      check_frame(vecs[i].ch, vecs[i].par);
      chk($sformatf("v%0d_busy_in_stop", i), {31'd0, busy}, 32'd1);
      sample();
      chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_txd_after", i), {31'd0, txd}, 32'd1);
      repeat (2) sample();
    end

    // Two characters on consecutive cycles: frames must abut.
    fork
      begin
        @(negedge clk);
        char_data  = 7'h41;
        char_valid = 1'b1;
        @(negedge clk);
        char_data  = 7'h42;
        @(negedge clk);
        char_valid = 1'b0;
      end
      begin
        sample();
        check_frame(7'h41, 1'b0);
        check_frame(7'h42, 1'b0);
      end
    join
    sample();
    chk("b2b_busy_after", {31'd0, busy}, 32'd0);
    repeat (2) sample();

    // Ten characters with valid held: nine accepted, tenth refused.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          char_data  = 7'(7'h30 + i);
          char_valid = 1'b1;
          chk($sformatf("burst_ready_%0d", i), {31'd0, char_ready}, (i < 9) ? 32'd1 : 32'd0);
        end
        sample();
        char_valid = 1'b0;
        chk("burst_count_full", {28'd0, fifo_count}, 32'd8);
        repeat (27) sample();
        chk("burst_ready_in_stop", {31'd0, char_ready}, 32'd0);
        sample();
        chk("burst_ready_after_stop", {31'd0, char_ready}, 32'd1);
        chk("burst_count_after_stop", {28'd0, fifo_count}, 32'd7);
      end
      begin
        logic [6:0] bch;
        logic       bpar;
        sample();
        for (int i = 0; i < 9; i++) begin
          bch  = 7'(7'h30 + i);
          bpar = ^bch;
          check_frame(bch, bpar);
        end
      end
    join
    sample();
    chk("burst_busy_after", {31'd0, busy}, 32'd0);
    chk("burst_count_after", {28'd0, fifo_count}, 32'd0);
    repeat (2) sample();

    // Reset asserted during data bit 3 of 7'h55 with 7'h2A still queued.
    push(7'h55);
    push(7'h2A);
    repeat (17) sample();
    chk("pre_reset_bit3", {31'd0, txd}, 32'd0);
    chk("pre_reset_count", {28'd0, fifo_count}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_txd", {31'd0, txd}, 32'd1);
    chk("async_rst_count", {28'd0, fifo_count}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, char_ready}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sample();
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("post_reset_idle_50", {31'd0, ok}, 32'd1);

    // Transmitter still works after the abort.
    push(7'h43);
    check_frame(7'h43, 1'b1);
    sample();
    chk("post_reset_busy_after", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
